// File: rtl/stim_seq_pkg.sv
// Shared types and constants for the stimulus/response sequencer.
// Holds the FSM state encoding and the fixed LFSR/MISR feedback tap masks.
package stim_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } seq_state_e;

    // Feedback taps for a 50-bit stimulus LFSR: bits 49, 48, 23, 22
    localparam logic [49:0] LFSR_TAPS = 50'h3_0000_00C0_0000;

    // Feedback taps for a 30-bit response MISR: bits 29, 5, 3, 0
    localparam logic [29:0] MISR_TAPS = 30'h2000_0029;

    localparam int MAX_RESP_LAT = 7;

endpackage

// File: rtl/misr_accum.sv
// Multiple-input signature register: shifts left with XOR feedback from TAPS
// and folds din into the state on every enabled edge; clr wins over en.
module misr_accum
    import stim_seq_pkg::*;
#(
    parameter int             W    = 30,
    parameter logic [W-1:0]   TAPS = {W{1'b0}}
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] sig
);

    logic [W-1:0] sig_r;
    logic         fb_s;

    assign fb_s = ^(sig_r & TAPS);
    assign sig  = sig_r;

    // Signature state: cleared by reset or clr, otherwise folds din when en
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r <= {W{1'b0}};
        end else if (clr) begin
            sig_r <= {W{1'b0}};
        end else if (en) begin
            sig_r <= {sig_r[W-2:0], fb_s} ^ din;
        end else begin
            sig_r <= sig_r;
        end
    end

endmodule

// File: rtl/stim_resp_sequencer.sv
// LFSR stimulus source plus MISR response compactor for a combinational DUT.
// Optional STIM_SIG_CMP_EN adds a golden-signature compare (golden_sig, pass).
module stim_resp_sequencer
    import stim_seq_pkg::*;
#(
    parameter int IN_W     = 50,
    parameter int OUT_W    = 30,
    parameter int NUM_VEC  = 256,
    parameter int RESP_LAT = 0
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             start,
    input  logic [IN_W-1:0]                  seed,
    output logic [IN_W-1:0]                  stim_o,
    output logic                             stim_valid,
    input  logic [OUT_W-1:0]                 resp_i,
    output logic                             busy,
    output logic                             done,
    output logic [$clog2(NUM_VEC+1)-1:0]     vec_count,
    output logic [OUT_W-1:0]                 signature
`ifdef STIM_SIG_CMP_EN
    ,
    input  logic [OUT_W-1:0]                 golden_sig,
    output logic                             pass
`endif
);

    localparam int               CW         = $clog2(NUM_VEC + 1);
    localparam int               DW         = $clog2(MAX_RESP_LAT + 1);
    localparam logic [CW-1:0]    VEC_LAST   = CW'(NUM_VEC - 1);
    localparam logic [CW-1:0]    VEC_MAX    = CW'(NUM_VEC);
    localparam logic [DW-1:0]    DRAIN_INIT = DW'(RESP_LAT - 1);
    localparam logic [IN_W-1:0]  LFSR_ONE   = {{(IN_W-1){1'b0}}, 1'b1};
    localparam logic [IN_W-1:0]  L_TAPS     = IN_W'(LFSR_TAPS);
    localparam logic [OUT_W-1:0] M_TAPS     = OUT_W'(MISR_TAPS);

    seq_state_e        state_r;
    logic [IN_W-1:0]   lfsr_r;
    logic              stim_valid_r;
    logic              busy_r;
    logic              done_r;
    logic [CW-1:0]     vec_count_r;
    logic [DW-1:0]     drain_cnt_r;
    logic              lfsr_fb_s;
    logic              resp_valid_s;
    logic              misr_clr_s;
    logic [OUT_W-1:0]  misr_sig_s;

    assign lfsr_fb_s  = ^(lfsr_r & L_TAPS);
    assign misr_clr_s = (state_r == ST_LOAD);

    assign stim_o     = lfsr_r;
    assign stim_valid = stim_valid_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign vec_count  = vec_count_r;
    assign signature  = misr_sig_s;

    // Sequencer FSM with LFSR, vector counter, drain timer and status flags
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            lfsr_r       <= {IN_W{1'b0}};
            stim_valid_r <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            vec_count_r  <= {CW{1'b0}};
            drain_cnt_r  <= {DW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_r <= ST_LOAD;
                        busy_r  <= 1'b1;
                        done_r  <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    // An all-zero LFSR would never leave zero, so substitute 1
                    lfsr_r       <= (seed == {IN_W{1'b0}}) ? LFSR_ONE : seed;
                    vec_count_r  <= {CW{1'b0}};
                    stim_valid_r <= 1'b1;
                    state_r      <= ST_RUN;
                end
                ST_RUN: begin
                    lfsr_r <= {lfsr_r[IN_W-2:0], lfsr_fb_s};
                    if (vec_count_r != VEC_MAX) begin
                        vec_count_r <= vec_count_r + CW'(1);
                    end
                    if (vec_count_r == VEC_LAST) begin
                        stim_valid_r <= 1'b0;
                        if (RESP_LAT > 0) begin
                            state_r     <= ST_DRAIN;
                            drain_cnt_r <= DRAIN_INIT;
                        end else begin
                            state_r <= ST_DONE;
                            busy_r  <= 1'b0;
                            done_r  <= 1'b1;
                        end
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == {DW{1'b0}}) begin
                        state_r <= ST_DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end else begin
                        drain_cnt_r <= drain_cnt_r - DW'(1);
                    end
                end
                default: begin
                    state_r      <= ST_IDLE;
                    stim_valid_r <= 1'b0;
                    busy_r       <= 1'b0;
                    done_r       <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (RESP_LAT == 0) begin : g_no_lat
            assign resp_valid_s = stim_valid_r;
        end else begin : g_lat
            logic [RESP_LAT-1:0] vpipe_r;

            // Delay line aligning stimulus valid with the returning response
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    vpipe_r <= {RESP_LAT{1'b0}};
                end else begin
                    vpipe_r <= (vpipe_r << 1) | RESP_LAT'(stim_valid_r);
                end
            end

            assign resp_valid_s = vpipe_r[RESP_LAT-1];
        end
    endgenerate

    misr_accum #(
        .W    (OUT_W),
        .TAPS (M_TAPS)
    ) u_misr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (misr_clr_s),
        .en    (resp_valid_s),
        .din   (resp_i),
        .sig   (misr_sig_s)
    );

`ifdef STIM_SIG_CMP_EN
    logic             pass_r;
    logic             enter_done_s;
    logic [OUT_W-1:0] misr_next_s;

    // The last response is folded on the same edge that enters DONE, so the
    // compare looks at the MISR value that edge will produce.
    always_comb begin
        enter_done_s = 1'b0;
        misr_next_s  = misr_sig_s;
        if (((state_r == ST_RUN) && (vec_count_r == VEC_LAST) && (RESP_LAT == 0)) ||
            ((state_r == ST_DRAIN) && (drain_cnt_r == {DW{1'b0}}))) begin
            enter_done_s = 1'b1;
        end else begin
            enter_done_s = 1'b0;
        end
        if (resp_valid_s) begin
            misr_next_s = {misr_sig_s[OUT_W-2:0], ^(misr_sig_s & M_TAPS)} ^ resp_i;
        end else begin
            misr_next_s = misr_sig_s;
        end
    end

    // Golden-signature verdict, cleared at the start of every run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pass_r <= 1'b0;
        end else if (state_r == ST_LOAD) begin
            pass_r <= 1'b0;
        end else if (enter_done_s) begin
            pass_r <= (misr_next_s == golden_sig);
        end else begin
            pass_r <= pass_r;
        end
    end

    assign pass = pass_r;
`endif

endmodule

// File: tb/tb_stim_resp_sequencer.sv
// Scoreboard bench: three sequencer instances (short/no latency, short/latency 3,
// full-length default) checked against an independent LFSR/MISR model.
`timescale 1ns/1ps
module tb_stim_resp_sequencer;

    localparam int IN_W  = 50;
    localparam int OUT_W = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    // instance 0: NUM_VEC=4, RESP_LAT=0, loopback
    logic start0; logic [IN_W-1:0] seed0; logic [IN_W-1:0] stim0; logic sv0;
    logic busy0, done0; logic [2:0] vc0; logic [OUT_W-1:0] sig0, resp0;
    // instance 3: NUM_VEC=4, RESP_LAT=3, loopback through 3 registers
    logic start3; logic [IN_W-1:0] seed3; logic [IN_W-1:0] stim3; logic sv3;
    logic busy3, done3; logic [2:0] vc3; logic [OUT_W-1:0] sig3, resp3, dly1, dly2, dly3;
    // instance n: default parameters, loopback or zero response
    logic start_n; logic [IN_W-1:0] seed_n; logic [IN_W-1:0] stim_n; logic sv_n;
    logic busy_n, done_n; logic [8:0] vc_n; logic [OUT_W-1:0] sig_n, resp_n;
    logic zero_n;
`ifdef STIM_SIG_CMP_EN
    logic [OUT_W-1:0] golden0; logic pass0, pass3, pass_n;
`endif

    assign resp0  = stim0[OUT_W-1:0];
    assign resp3  = dly3;
    assign resp_n = zero_n ? {OUT_W{1'b0}} : stim_n[OUT_W-1:0];

    always @(posedge clk) begin
        dly1 <= stim3[OUT_W-1:0];
        dly2 <= dly1;
        dly3 <= dly2;
    end

    stim_resp_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(4), .RESP_LAT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .seed(seed0), .stim_o(stim0),
        .stim_valid(sv0), .resp_i(resp0), .busy(busy0), .done(done0),
        .vec_count(vc0), .signature(sig0)
`ifdef STIM_SIG_CMP_EN
        , .golden_sig(golden0), .pass(pass0)
`endif
    );

    stim_resp_sequencer #(.IN_W(IN_W), .OUT_W(OUT_W), .NUM_VEC(4), .RESP_LAT(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .seed(seed3), .stim_o(stim3),
        .stim_valid(sv3), .resp_i(resp3), .busy(busy3), .done(done3),
        .vec_count(vc3), .signature(sig3)
`ifdef STIM_SIG_CMP_EN
        , .golden_sig(30'h0000_0007), .pass(pass3)
`endif
    );

    stim_resp_sequencer dutn (
        .clk(clk), .rst_n(rst_n), .start(start_n), .seed(seed_n), .stim_o(stim_n),
        .stim_valid(sv_n), .resp_i(resp_n), .busy(busy_n), .done(done_n),
        .vec_count(vc_n), .signature(sig_n)
`ifdef STIM_SIG_CMP_EN
        , .golden_sig(30'h0000_0000), .pass(pass_n)
`endif
    );

    function automatic logic [49:0] m_lfsr(input logic [49:0] x);
        return {x[48:0], x[49] ^ x[48] ^ x[23] ^ x[22]};
    endfunction

    function automatic logic [29:0] m_misr(input logic [29:0] m, input logic [29:0] d);
        return {m[28:0], m[29] ^ m[5] ^ m[3] ^ m[0]} ^ d;
    endfunction

    function automatic logic [49:0] rand_seed();
        logic [63:0] r;
        r = {$urandom(), $urandom()};
        return r[49:0];
    endfunction

    logic [IN_W-1:0] exp_q0[$];
    logic [IN_W-1:0] exp_qn[$];

    // stimulus scoreboards: pop one expected vector per live stimulus cycle
    always @(negedge clk) begin
        logic [IN_W-1:0] e;
        if (sv0) begin
            n_checks++;
            if (exp_q0.size() == 0) begin
                n_fail++;
                $display("FAIL stim0_extra: got %h, none expected", stim0);
            end else begin
                e = exp_q0.pop_front();
                if (stim0 !== e) begin
                    n_fail++;
                    $display("FAIL stim0_vec: got %h, expected %h", stim0, e);
                end
            end
        end
        if (sv_n) begin
            n_checks++;
            if (exp_qn.size() == 0) begin
                n_fail++;
                $display("FAIL stimn_extra: got %h, none expected", stim_n);
            end else begin
                e = exp_qn.pop_front();
                if (stim_n !== e) begin
                    n_fail++;
                    $display("FAIL stimn_vec: got %h, expected %h", stim_n, e);
                end
            end
        end
    end

    // pushes expected vectors and returns the model signature for a loopback run
    task automatic push_vecs(input logic [49:0] seed, input int n, input bit to_n,
                             output logic [29:0] exp_sig);
        logic [49:0] s;
        s = (seed == 50'd0) ? 50'd1 : seed;
        exp_sig = 30'd0;
        for (int i = 0; i < n; i++) begin
            if (to_n) exp_qn.push_back(s);
            else      exp_q0.push_back(s);
            exp_sig = m_misr(exp_sig, s[29:0]);
            s = m_lfsr(s);
        end
    endtask

    task automatic run_d0(input logic [49:0] seed, input int poke, output int edges);
        seed0 = seed; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0; edges = 1;
        while (!done0 && edges < 40) begin
            start0 = (edges == poke);
            @(negedge clk); edges++;
        end
        start0 = 1'b0;
        if (!done0) begin
            n_checks++; n_fail++;
            $display("FAIL d0_timeout: done=%b after %0d edges, expected 1", done0, edges);
        end
    endtask

    task automatic run_d3(input logic [49:0] seed, input int poke, output int edges, output int fall);
        logic prev;
        seed3 = seed; start3 = 1'b1; prev = 1'b0; fall = 0;
        @(negedge clk); start3 = 1'b0; edges = 1;
        while (!done3 && edges < 40) begin
            start3 = (edges == poke);
            prev = sv3;
            @(negedge clk); edges++;
            if (prev && !sv3) fall = edges;
        end
        start3 = 1'b0;
        if (!done3) begin
            n_checks++; n_fail++;
            $display("FAIL d3_timeout: done=%b after %0d edges, expected 1", done3, edges);
        end
    endtask

    task automatic run_n(input logic [49:0] seed, output int edges);
        seed_n = seed; start_n = 1'b1;
        @(negedge clk); start_n = 1'b0; edges = 1;
        while (!done_n && edges < 400) begin
            @(negedge clk); edges++;
        end
        if (!done_n) begin
            n_checks++; n_fail++;
            $display("FAIL dn_timeout: done=%b after %0d edges, expected 1", done_n, edges);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start0 = 1'b0; start3 = 1'b0; start_n = 1'b0;
        seed0 = '0; seed3 = '0; seed_n = '0; zero_n = 1'b0;
`ifdef STIM_SIG_CMP_EN
        golden0 = 30'h7;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);
        n_checks += 8;
        if (stim0 !== '0)  begin n_fail++; $display("FAIL rst_stim: got %h, expected 0", stim0); end
        if (sv0 !== 1'b0)  begin n_fail++; $display("FAIL rst_valid: got %b, expected 0", sv0); end
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b, expected 0", busy0); end
        if (done0 !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b, expected 0", done0); end
        if (vc0 !== 3'd0)  begin n_fail++; $display("FAIL rst_vc: got %0d, expected 0", vc0); end
        if (sig0 !== 30'd0) begin n_fail++; $display("FAIL rst_sig: got %h, expected 0", sig0); end
        if (sig_n !== 30'd0) begin n_fail++; $display("FAIL rst_sig_n: got %h, expected 0", sig_n); end
        if (busy3 !== 1'b0) begin n_fail++; $display("FAIL rst_busy3: got %b, expected 0", busy3); end
    endtask

    task automatic test_loopback();
        int e; logic [29:0] xs; logic [49:0] sd;
        push_vecs(50'd0, 4, 1'b0, xs);
        run_d0(50'd0, 0, e);
        n_checks += 5;
        if (e !== 6)         begin n_fail++; $display("FAIL lb_edges: got %0d, expected 6", e); end
        if (sig0 !== 30'h7)  begin n_fail++; $display("FAIL lb_sig: got %h, expected 7", sig0); end
        if (vc0 !== 3'd4)    begin n_fail++; $display("FAIL lb_vc: got %0d, expected 4", vc0); end
        if (busy0 !== 1'b0)  begin n_fail++; $display("FAIL lb_busy: got %b, expected 0", busy0); end
        if (exp_q0.size() != 0) begin n_fail++; $display("FAIL lb_count: %0d vectors missing, expected 0", exp_q0.size()); end
        sd = rand_seed();
        push_vecs(sd, 4, 1'b0, xs);
        run_d0(sd, 0, e);
        n_checks++;
        if (sig0 !== xs) begin n_fail++; $display("FAIL lb_rand_sig: got %h, expected %h", sig0, xs); end
    endtask

    task automatic test_latency();
        int e, f;
        run_d3(50'd0, 0, e, f);
        n_checks += 4;
        if (e !== 9)        begin n_fail++; $display("FAIL lat_edges: got %0d, expected 9", e); end
        if (e - f !== 3)    begin n_fail++; $display("FAIL lat_drain: got %0d, expected 3", e - f); end
        if (sig3 !== 30'h7) begin n_fail++; $display("FAIL lat_sig: got %h, expected 7", sig3); end
        if (vc3 !== 3'd4)   begin n_fail++; $display("FAIL lat_vc: got %0d, expected 4", vc3); end
`ifdef STIM_SIG_CMP_EN
        n_checks++;
        if (pass3 !== 1'b1) begin n_fail++; $display("FAIL lat_pass: got %b, expected 1", pass3); end
`endif
    endtask

    task automatic test_long_runs();
        int e; logic [29:0] xs; logic [49:0] sd;
        zero_n = 1'b1; sd = rand_seed();
        push_vecs(sd, 256, 1'b1, xs);
        run_n(sd, e);
        n_checks += 3;
        if (sig_n !== 30'd0) begin n_fail++; $display("FAIL zero_sig: got %h, expected 0", sig_n); end
        if (vc_n !== 9'd256) begin n_fail++; $display("FAIL zero_vc: got %0d, expected 256", vc_n); end
        if (e !== 258)       begin n_fail++; $display("FAIL zero_edges: got %0d, expected 258", e); end
        repeat (5) @(negedge clk);
        n_checks += 2;
        if (vc_n !== 9'd256) begin n_fail++; $display("FAIL sat_vc: got %0d, expected 256", vc_n); end
        if (done_n !== 1'b1) begin n_fail++; $display("FAIL hold_done: got %b, expected 1", done_n); end
        zero_n = 1'b0; sd = rand_seed();
        push_vecs(sd, 256, 1'b1, xs);
        run_n(sd, e);
        n_checks++;
        if (sig_n !== xs) begin n_fail++; $display("FAIL long_sig: got %h, expected %h", sig_n, xs); end
    endtask

    task automatic test_start_ignored();
        int e, f; logic [29:0] xs;
        push_vecs(50'd0, 4, 1'b0, xs);
        run_d0(50'd0, 3, e);
        run_d3(50'd0, 7, e, f);
        n_checks += 3;
        if (sig0 !== 30'h7) begin n_fail++; $display("FAIL ign_run_sig: got %h, expected 7", sig0); end
        if (sig3 !== 30'h7) begin n_fail++; $display("FAIL ign_drain_sig: got %h, expected 7", sig3); end
        if (e !== 9)        begin n_fail++; $display("FAIL ign_drain_edges: got %0d, expected 9", e); end
    endtask

    task automatic test_reset_mid_run();
        int e; logic [29:0] xs;
        push_vecs(50'd0, 4, 1'b0, xs);
        seed0 = '0; start0 = 1'b1;
        @(negedge clk); start0 = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks += 5;
        if (stim0 !== '0)   begin n_fail++; $display("FAIL mid_rst_stim: got %h, expected 0", stim0); end
        if (sv0 !== 1'b0)   begin n_fail++; $display("FAIL mid_rst_valid: got %b, expected 0", sv0); end
        if (busy0 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_busy: got %b, expected 0", busy0); end
        if (vc0 !== 3'd0)   begin n_fail++; $display("FAIL mid_rst_vc: got %0d, expected 0", vc0); end
        if (sig0 !== 30'd0) begin n_fail++; $display("FAIL mid_rst_sig: got %h, expected 0", sig0); end
        exp_q0.delete();
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
        push_vecs(50'd0, 4, 1'b0, xs);
        run_d0(50'd0, 0, e);
        n_checks += 2;
        if (sig0 !== 30'h7) begin n_fail++; $display("FAIL post_rst_sig: got %h, expected 7", sig0); end
        if (e !== 6)        begin n_fail++; $display("FAIL post_rst_edges: got %0d, expected 6", e); end
    endtask

`ifdef STIM_SIG_CMP_EN
    task automatic test_pass();
        int e; logic [29:0] xs;
        golden0 = 30'h7;
        push_vecs(50'd0, 4, 1'b0, xs);
        run_d0(50'd0, 0, e);
        n_checks++;
        if (pass0 !== 1'b1) begin n_fail++; $display("FAIL pass_good: got %b, expected 1", pass0); end
        seed0 = '0; start0 = 1'b1;
        push_vecs(50'd0, 4, 1'b0, xs);
        @(negedge clk); start0 = 1'b0;
        @(negedge clk);
        n_checks++;
        if (pass0 !== 1'b0) begin n_fail++; $display("FAIL pass_load_clr: got %b, expected 0", pass0); end
        repeat (6) @(negedge clk);
        n_checks++;
        if (pass0 !== 1'b1) begin n_fail++; $display("FAIL pass_again: got %b, expected 1", pass0); end
        golden0 = 30'h6;
        push_vecs(50'd0, 4, 1'b0, xs);
        run_d0(50'd0, 0, e);
        n_checks++;
        if (pass0 !== 1'b0) begin n_fail++; $display("FAIL pass_bad: got %b, expected 0", pass0); end
    endtask
`endif

    initial begin
        test_reset();
        test_loopback();
        test_latency();
        test_long_runs();
        test_start_ignored();
        test_reset_mid_run();
`ifdef STIM_SIG_CMP_EN
        test_pass();
`endif
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stim_resp_sequencer.md
Name: stim_resp_sequencer

Overview:
- Self-running stimulus source and response compactor for a combinational DUT with an IN_W-bit input and an OUT_W-bit output.
- Drives pseudo-random input vectors from an LFSR and folds every DUT response into a MISR signature.
- Lets the original and the instruction-reduced netlists be compared by a single signature per run, with no file I/O per vector.
- Sits beside the DUT inside the bench wrapper: stim_o feeds the DUT input, and the DUT output returns on resp_i.

Parameters:
- IN_W, 50, stimulus vector width (DUT input width).
- OUT_W, 30, response width (DUT output width).
- NUM_VEC, 256, vectors issued per run; must be at least 1.
- RESP_LAT, 0, cycles between a vector being presented and its response being valid; range 0..7.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle run request; honoured only in IDLE or DONE.
- seed  in  IN_W  LFSR seed, sampled in LOAD.
- stim_o  out  IN_W  current stimulus vector.
- stim_valid  out  1  stim_o holds a live vector this cycle.
- resp_i  in  OUT_W  DUT response.
- busy  out  1  high in LOAD, RUN and DRAIN.
- done  out  1  run complete; held high until the next start or reset.
- vec_count  out  $clog2(NUM_VEC+1)  vectors issued in the current run.
- signature  out  OUT_W  MISR value; final once done=1.

Behaviour:
- Reset (async assert, sync release): state=IDLE; stim_o, stim_valid, busy, done, vec_count and signature all 0.
- FSM states: IDLE, LOAD, RUN, DRAIN, DONE.
- IDLE or DONE, start=1 -> LOAD. done clears on that same edge.
- LOAD, one cycle:
  - LFSR <= seed, or 1 if seed==0 (the all-zero lock-up state is forbidden).
  - MISR <= 0; vec_count <= 0.
  - Then -> RUN.
- RUN:
  - stim_valid=1 and stim_o=LFSR every cycle.
  - Each cycle: LFSR <= {L[IN_W-2:0], L[49]^L[48]^L[23]^L[22]} (taps fixed for IN_W=50); vec_count increments.
  - After NUM_VEC cycles: -> DRAIN if RESP_LAT>0, else -> DONE.
  - stim_valid falls on the same edge the FSM leaves RUN.
- Response pipeline:
  - stim_valid is delayed RESP_LAT stages.
  - On each edge where the delayed valid is 1: MISR <= {M[OUT_W-2:0], M[29]^M[5]^M[3]^M[0]} ^ resp_i (taps fixed for OUT_W=30).
  - With RESP_LAT=0, resp_i is sampled on the same edge that advances the LFSR.
- DRAIN: lasts exactly RESP_LAT cycles, stim_valid=0, then -> DONE.
- Absorption count: exactly NUM_VEC responses per run.
- DONE: busy=0, done=1; signature and vec_count hold.
- start while busy: ignored; no restart and no state change.
- Reset mid-run: immediate return to the reset state. Partial signature is discarded.
- signature always presents the live MISR value. It is meaningful only when done=1.
- vec_count saturates at NUM_VEC; it never wraps.

Optional Feature:
- Macro: STIM_SIG_CMP_EN.
- Defined:
  - Adds input golden_sig [OUT_W-1:0] and output pass [1].
  - pass is registered on the edge entering DONE: 1 if MISR == golden_sig, else 0.
  - pass is cleared to 0 by reset and in LOAD.
- Undefined: neither port exists; no compare logic.

Decomposition:
- Package stim_seq_pkg holds:
  - state enum (IDLE, LOAD, RUN, DRAIN, DONE);
  - LFSR_TAPS, 50-bit mask with bits 49, 48, 23, 22 set;
  - MISR_TAPS, 30-bit mask with bits 29, 5, 3, 0 set;
  - MAX_RESP_LAT = 7.
- One sub-module, misr_accum: parameterised width and tap mask; inputs clk, rst_n, clr, en, din; output sig. Reused for the response path.
- FSM, LFSR and latency pipe stay in the top module.

Test Plan:
- Reset, no start for 10 cycles -> all outputs 0, state IDLE.
- NUM_VEC=4, RESP_LAT=0, seed=0, resp_i=stim_o[29:0] (loopback):
  - stim_o sequence is 1, 2, 4, 8 (the zero seed is substituted with 1);
  - done=1 on the 6th edge after start (1 IDLE->LOAD, 1 LOAD, 4 RUN);
  - signature=30'h7; vec_count=4.
- Same as the previous scenario but RESP_LAT=3, with resp_i fed through a 3-stage register delay -> signature=30'h7; DRAIN lasts 3 cycles; done 3 cycles later.
- resp_i tied to 0, any seed -> signature=0 after the run; vec_count=NUM_VEC.
- start pulsed mid-RUN and in DRAIN -> ignored; signature identical to an undisturbed run. rst_n low at vector 2 -> outputs 0 asynchronously; a new start gives a correct run.
- STIM_SIG_CMP_EN defined, loopback scenario:
  - golden_sig=30'h7 -> pass=1;
  - golden_sig=30'h6 -> pass=0;
  - the next start clears pass in LOAD.
